// File: rtl/fmadd_result_rounder.sv
// Narrows the wide FMADD result to the 33-bit unpacked operand: normalise, round (RISC-V rm), flag.
// Latency k+2 cycles for k shifts (zero: 1); one item in flight; in_ready only in IDLE, DONE holds until out_ready.
module fmadd_result_rounder #(
  parameter int std = 31,
  parameter int man = 22,
  parameter int exp = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2+exp+2*(man+2):0]   in_data,
  input  logic [2:0]                 in_rm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [std+1:0]             out_data,
  output logic [2:0]                 out_flags
);

  localparam int EW = exp + 2;
  localparam int SW = 2 * (man + 2);
  localparam int KW = man + 2;
  localparam int DW = 3 + exp + 2 * (man + 2);
  localparam logic [EW:0] EMAX = {2'b00, {(exp + 1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_sign;
  logic [EW-1:0]     r_exp;
  logic [SW-1:0]     r_sig;
  logic [2:0]        r_rm;
  logic              r_zero;
  logic [std+1:0]    r_out_data;
  logic [2:0]        r_out_flags;

  logic              w_in_sign;
  logic [EW-1:0]     w_in_exp;
  logic [SW-1:0]     w_in_sig;
  logic              w_accept;
  logic              w_shift;

  assign w_in_sign = in_data[DW-1];
  assign w_in_exp  = in_data[SW+EW-1:SW];
  assign w_in_sig  = in_data[SW-1:0];
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_shift   = !r_sig[SW-1] && (r_exp > EW'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Zero inputs skip NORM but still pass through ROUND, giving them a one-cycle latency.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = (w_in_sig == '0) ? S_ROUND : S_NORM;
      end
      S_NORM:  if (!w_shift) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  logic [KW-1:0]  w_k;
  logic           w_g;
  logic           w_t;
  logic           w_tiny;
  logic           w_inc;
  logic [KW:0]    w_sum;
  logic           w_carry;
  logic [KW-1:0]  w_kr;
  logic [EW:0]    w_efin;
  logic           w_ovf;
  logic [exp:0]   w_efield;
  logic           w_inf_sel;
  logic [std+1:0] w_res;
  logic [2:0]     w_flags;

  assign w_k    = r_sig[SW-1 -: KW];
  assign w_g    = r_sig[SW-KW-1];
  assign w_t    = |r_sig[SW-KW-2:0];
  assign w_tiny = !r_sig[SW-1];

  always_comb begin
    w_inc     = w_g & (w_t | w_k[0]);
    w_inf_sel = 1'b1;
    case (r_rm)
      3'b001: begin w_inc = 1'b0;                      w_inf_sel = 1'b0;     end
      3'b010: begin w_inc = r_sign & (w_g | w_t);      w_inf_sel = r_sign;   end
      3'b011: begin w_inc = !r_sign & (w_g | w_t);     w_inf_sel = !r_sign;  end
      3'b100: begin w_inc = w_g;                       w_inf_sel = 1'b1;     end
      default: begin w_inc = w_g & (w_t | w_k[0]);     w_inf_sel = 1'b1;     end
    endcase
  end

  assign w_sum   = {1'b0, w_k} + {{KW{1'b0}}, w_inc};
  assign w_carry = w_sum[KW];
  assign w_kr    = w_carry ? {1'b1, {(KW-1){1'b0}}} : w_sum[KW-1:0];
  assign w_efin  = {1'b0, r_exp} + {{EW{1'b0}}, w_carry};
  assign w_ovf   = (w_efin >= EMAX);
  // A subnormal that rounds up into the hidden bit becomes the smallest normal.
  assign w_efield = w_tiny ? {{exp{1'b0}}, w_kr[KW-1]} : w_efin[exp:0];

  always_comb begin
    w_res   = {r_sign, w_efield, w_kr};
    w_flags = {w_g | w_t | w_ovf, w_tiny & (w_g | w_t), w_ovf};
    if (r_zero) begin
      w_res   = {r_sign, {(std+1){1'b0}}};
      w_flags = 3'b000;
    end else if (w_ovf) begin
      if (w_inf_sel) w_res = {r_sign, {(exp+1){1'b1}}, {KW{1'b0}}};
      else           w_res = {r_sign, {exp{1'b1}}, 1'b0, {KW{1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_sig       <= '0;
      r_rm        <= '0;
      r_zero      <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else begin
      if (w_accept) begin
        r_sign <= w_in_sign;
        r_exp  <= (w_in_exp == '0) ? EW'(1) : w_in_exp;
        r_sig  <= w_in_sig;
        r_rm   <= in_rm;
        r_zero <= (w_in_sig == '0);
      end
      if (r_state == S_NORM && w_shift) begin
        r_sig <= {r_sig[SW-2:0], 1'b0};
        r_exp <= r_exp - EW'(1);
      end
      if (r_state == S_ROUND) begin
        r_out_data  <= w_res;
        r_out_flags <= w_flags;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fmadd_result_rounder.sv
// Self-checking bench for fmadd_result_rounder: directed cases plus randomized traffic against an arithmetic model.
module tb_fmadd_result_rounder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [57:0] in_data = '0;
  logic [2:0]  in_rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [32:0] out_data;
  logic [2:0]  out_flags;

  int n_cmp = 0;
  int n_bad = 0;

  fmadd_result_rounder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // Reference: value arithmetic on the significand, leading-one search for the shift count.
  function automatic void model(input logic sg, input logic [8:0] e_in, input logic [47:0] s_in,
                                input logic [2:0] rm, output logic [32:0] d, output logic [2:0] f,
                                output int lat);
    longint unsigned s, kk, rem;
    int e, msb, k;
    bit up, tiny, ovf, inf;
    s = 64'(s_in);
    e = int'(e_in);
    if (s == 0) begin
      d = {sg, 32'd0}; f = 3'b000; lat = 1;
      return;
    end
    if (e == 0) e = 1;
    msb = 0;
    for (int i = 0; i < 48; i++) if (s_in[i]) msb = i;
    k = 47 - msb;
    if (k > e - 1) k = e - 1;
    s = s << k;
    e = e - k;
    lat = k + 2;
    tiny = (s < 64'h8000_0000_0000);
    kk = s >> 24;
    rem = s & 64'hFF_FFFF;
    case (rm)
      3'd1: up = 1'b0;
      3'd2: up = sg && (rem != 0);
      3'd3: up = !sg && (rem != 0);
      3'd4: up = (rem >= 64'h80_0000);
      default: up = (rem > 64'h80_0000) || (rem == 64'h80_0000 && kk[0]);
    endcase
    kk = kk + 64'(up);
    if (kk == 64'h100_0000) begin
      kk = 64'h80_0000;
      e = e + 1;
    end
    ovf = (e >= 255);
    f = {(rem != 0) || ovf, tiny && (rem != 0), ovf};
    if (ovf) begin
      inf = (rm == 3'd1) ? 1'b0 : (rm == 3'd2) ? sg : (rm == 3'd3) ? !sg : 1'b1;
      d = inf ? {sg, 8'hFF, 24'h0} : {sg, 8'hFE, 24'hFF_FFFF};
    end else begin
      d = {sg, tiny ? ((kk >= 64'h80_0000) ? 8'd1 : 8'd0) : 8'(e), 24'(kk)};
    end
  endfunction

  // Drives one item; lat counts clock edges from the accept edge to out_valid.
  task automatic do_txn(input logic sg, input logic [8:0] e, input logic [47:0] s, input logic [2:0] rm,
                        input bit handshake, output logic [32:0] d, output logic [2:0] f, output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1;
    in_data  = {sg, e, s};
    in_rm    = rm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 58'({$urandom, $urandom});
    in_rm    = rm ^ 3'($urandom_range(1, 7));
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    d = out_data;
    f = out_flags;
    if (handshake && out_valid) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_flags, out_data} !== {1'b1, 1'b0, 3'b000, 33'd0}) begin
      n_bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b flags=%b data=%h, required 1 0 000 000000000",
               in_ready, out_valid, out_flags, out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normalised();
    logic [32:0] d; logic [2:0] f; int lat;
    do_txn(1'b0, 9'h07F, 48'h800000_000000, 3'd0, 1'b1, d, f, lat);
    n_cmp++;
    if (d !== {1'b0, 8'h7F, 24'h800000} || f !== 3'b000 || lat !== 2) begin
      n_bad++;
      $display("FAIL normalised: data=%h flags=%b lat=%0d, required %h 000 2", d, f, lat, {1'b0, 8'h7F, 24'h800000});
    end
  endtask

  task automatic test_cancellation();
    logic [32:0] d; logic [2:0] f; int lat;
    do_txn(1'b0, 9'h07F, 48'h000001_000000, 3'd0, 1'b1, d, f, lat);
    n_cmp++;
    if (d !== {1'b0, 8'h68, 24'h800000} || f !== 3'b000 || lat !== 25) begin
      n_bad++;
      $display("FAIL cancellation: data=%h flags=%b lat=%0d, required %h 000 25", d, f, lat, {1'b0, 8'h68, 24'h800000});
    end
    // Denormal input exponent is read as 1, so no shifts and a subnormal result.
    do_txn(1'b0, 9'h000, 48'h000001_000000, 3'd0, 1'b1, d, f, lat);
    n_cmp++;
    if (d !== {1'b0, 8'h00, 24'h000001} || f !== 3'b000 || lat !== 2) begin
      n_bad++;
      $display("FAIL e_zero_in: data=%h flags=%b lat=%0d, required %h 000 2", d, f, lat, {1'b0, 8'h00, 24'h000001});
    end
  endtask

  task automatic test_round_modes();
    logic [32:0] d; logic [2:0] f; int lat;
    logic [2:0]  rms  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [23:0] sigs [6] = '{24'h800002, 24'h800001, 24'h800001, 24'h800002, 24'h800002, 24'h800002};
    for (int i = 0; i < 6; i++) begin
      do_txn(1'b0, 9'h07F, 48'h800001_800000, rms[i], 1'b1, d, f, lat);
      n_cmp++;
      if (d !== {1'b0, 8'h7F, sigs[i]} || f !== 3'b100) begin
        n_bad++;
        $display("FAIL round_rm%0d: data=%h flags=%b, required %h 100", rms[i], d, f, {1'b0, 8'h7F, sigs[i]});
      end
    end
  endtask

  task automatic test_overflow();
    logic [32:0] d; logic [2:0] f; int lat;
    logic        sgs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0]  es  [7] = '{9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE, 9'h100, 9'h1FF};
    logic [2:0]  rms [7] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd3, 3'd1, 3'd4};
    logic [32:0] exd [7] = '{{1'b0, 8'hFF, 24'h0}, {1'b0, 8'hFE, 24'hFFFFFF}, {1'b0, 8'hFF, 24'h0},
                             {1'b1, 8'hFF, 24'h0}, {1'b1, 8'hFE, 24'hFFFFFF}, {1'b0, 8'hFE, 24'hFFFFFF},
                             {1'b0, 8'hFF, 24'h0}};
    logic [2:0]  exf [7] = '{3'b101, 3'b100, 3'b101, 3'b101, 3'b100, 3'b101, 3'b101};
    for (int i = 0; i < 7; i++) begin
      do_txn(sgs[i], es[i], (i < 5) ? 48'hFFFFFF_800000 : 48'h800000_000000, rms[i], 1'b1, d, f, lat);
      n_cmp++;
      if (d !== exd[i] || f !== exf[i]) begin
        n_bad++;
        $display("FAIL overflow_%0d: data=%h flags=%b, required %h %b", i, d, f, exd[i], exf[i]);
      end
    end
  endtask

  task automatic test_subnormal_zero();
    logic [32:0] d; logic [2:0] f; int lat;
    do_txn(1'b0, 9'h001, 48'h400000_000001, 3'd0, 1'b1, d, f, lat);
    n_cmp++;
    if (d !== {1'b0, 8'h00, 24'h400000} || f !== 3'b110 || lat !== 2) begin
      n_bad++;
      $display("FAIL subnormal: data=%h flags=%b lat=%0d, required %h 110 2", d, f, lat, {1'b0, 8'h00, 24'h400000});
    end
    do_txn(1'b0, 9'h001, 48'h7FFFFF_800000, 3'd0, 1'b1, d, f, lat);
    n_cmp++;
    if (d !== {1'b0, 8'h01, 24'h800000} || f !== 3'b110) begin
      n_bad++;
      $display("FAIL sub_to_normal: data=%h flags=%b, required %h 110", d, f, {1'b0, 8'h01, 24'h800000});
    end
    do_txn(1'b1, 9'h1FF, 48'h0, 3'd3, 1'b1, d, f, lat);
    n_cmp++;
    if (d !== {1'b1, 32'd0} || f !== 3'b000 || lat !== 1) begin
      n_bad++;
      $display("FAIL zero: data=%h flags=%b lat=%0d, required %h 000 1", d, f, lat, {1'b1, 32'd0});
    end
  endtask

  task automatic test_random();
    logic [32:0] d, ed; logic [2:0] f, ef; int lat, elat;
    logic sg; logic [8:0] e; logic [47:0] s; logic [2:0] rm; logic [63:0] r;
    for (int i = 0; i < 80; i++) begin
      sg = 1'($urandom);
      case ($urandom_range(0, 3))
        0: e = 9'($urandom_range(0, 3));
        1: e = 9'($urandom_range(250, 260));
        2: e = 9'($urandom);
        default: e = 9'($urandom_range(100, 150));
      endcase
      r = {$urandom, $urandom};
      s = r[47:0] >> $urandom_range(0, 48);
      if ($urandom_range(0, 3) == 0) s[23:0] = 24'h800000;
      rm = 3'($urandom);
      model(sg, e, s, rm, ed, ef, elat);
      do_txn(sg, e, s, rm, 1'b1, d, f, lat);
      n_cmp++;
      if (d !== ed || f !== ef || lat !== elat) begin
        n_bad++;
        $display("FAIL random_%0d (s=%b e=%h sig=%h rm=%0d): data=%h flags=%b lat=%0d, required %h %b %0d",
                 i, sg, e, s, rm, d, f, lat, ed, ef, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] d, ed; logic [2:0] f, ef; int lat, elat;
    model(1'b1, 9'h090, 48'h003456_789ABC, 3'd4, ed, ef, elat);
    do_txn(1'b1, 9'h090, 48'h003456_789ABC, 3'd4, 1'b0, d, f, lat);
    n_cmp++;
    if (d !== ed || f !== ef || lat !== elat) begin
      n_bad++;
      $display("FAIL bp_result: data=%h flags=%b lat=%0d, required %h %b %0d", d, f, lat, ed, ef, elat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ed || out_flags !== ef) begin
        n_bad++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b data=%h flags=%b, required 1 0 %h %b",
                 i, out_valid, in_ready, out_data, out_flags, ed, ef);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    logic [32:0] d; logic [2:0] f; int lat;
    in_valid = 1'b1;
    in_data  = {1'b0, 9'h07F, 48'h000001_000000};
    in_rm    = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_busy: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_flags, out_data} !== {1'b1, 1'b0, 3'b000, 33'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b flags=%b data=%h, required 1 0 000 000000000",
               in_ready, out_valid, out_flags, out_data);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_no_output: out_valid cycles=%0d, required 0", seen);
    end
    do_txn(1'b0, 9'h07F, 48'h800000_000000, 3'd0, 1'b1, d, f, lat);
    n_cmp++;
    if (d !== {1'b0, 8'h7F, 24'h800000} || f !== 3'b000 || lat !== 2) begin
      n_bad++;
      $display("FAIL post_reset: data=%h flags=%b lat=%0d, required %h 000 2", d, f, lat, {1'b0, 8'h7F, 24'h800000});
    end
  endtask

  initial begin
    test_reset();
    test_normalised();
    test_cancellation();
    test_round_modes();
    test_overflow();
    test_subnormal_zero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
